vga_char_display: RTL and testbench
===================================

# vga_char_display

Character-cell pixel generator directly downstream of the VGA timer. It consumes the timer's `x`, `y`, `activevideo`, `hsync` and `vsync`, and looks up the character code for the current 16×16 cell in screen memory. It then looks up that character's pixel colour in bitmap memory and drives 12-bit RGB plus sync outputs, all aligned through a fixed 3-cycle pipeline. It sits between the timer and the board's VGA pins, with the screen and bitmap memories alongside.

## Interface
Parameters:
- `COLS`, 40: character columns (640/16).
- `ROWS`, 30: character rows (480/16).
- `CHARBITS`, 4: width of a character code; bitmap holds 2^CHARBITS glyphs.
- `SMEM_AW`, 11: screen memory address width (enough for 1200 cells).

Ports:
- `clk`  in  1: 100 MHz system clock; the only clock.
- `reset`  in  1: asynchronous, active-high reset.
- `x`  in  `xbits`: timer column.
- `y`  in  `ybits`: timer row.
- `activevideo`  in  1: timer visible-area flag.
- `hsync_in`, `vsync_in`  in  1 each: timer syncs, active-low.
- `smem_addr`  out  SMEM_AW: screen memory address.
- `charcode`  in  CHARBITS: screen memory read data, combinational from `smem_addr`.
- `bmem_addr`  out  CHARBITS+8: bitmap memory address.
- `bmem_color`  in  12: bitmap read data {R4,G4,B4}, combinational from `bmem_addr`.
- `red`, `green`, `blue`  out  4 each: pixel colour.
- `hsync`, `vsync`  out  1 each: delayed syncs, active-low.
- `cursor_col`  in  6, and `cursor_row`  in  5: present only with `VGA_CURSOR_EN`.

## Operation
- The pipeline advances every `clk`; there is no stall or handshake. The timer holds `x`/`y` for 4 clocks, so each pixel passes through the pipeline four times with identical results.
- Stage 1 registers `x`, `y`, `activevideo` and both syncs.
  - Column is `col = x[9:4]`; row is `row = y[8:4]`.
  - `smem_addr = row*COLS + col`, computed at SMEM_AW width with no truncation for legal coordinates; range 0..1199.
  - Coordinates outside the visible area may produce out-of-range addresses. The memory must tolerate this, and the result is masked by blanking.
- Stage 2 registers `charcode` plus `y[3:0]`, `x[3:0]`, `activevideo` and the syncs from stage 1.
  - `bmem_addr = {charcode, y[3:0], x[3:0]}`.
- Stage 3 registers the output colour.
  - `{red,green,blue} = bmem_color` when the stage-2 `activevideo` is 1; otherwise 12'h000.
  - `hsync`/`vsync` are the stage-2 syncs re-registered.

## Timing
- Latency: inputs sampled at edge N appear on `red/green/blue/hsync/vsync` after edge N+3. Colour and syncs stay exactly aligned.
- `smem_addr` is valid 1 cycle after sampling; `bmem_addr` is valid 2 cycles after sampling.
- Reset values (asynchronous, immediate on `reset` high):
  - `smem_addr` = 0, `bmem_addr` = 0.
  - `red/green/blue` = 0.
  - `hsync` = 1, `vsync` = 1 (inactive).
  - All internal pipeline registers cleared, with their `activevideo` bits = 0 and sync bits = 1.
  - Cursor frame counter = 0.
- Reset mid-frame: outputs go to their reset values at once. After release, the first 3 cycles output blank pixels with inactive syncs, then valid pixels resume from the timer's current position. No frame resynchronisation is attempted.
- Bottom-right cell (col 39, row 29) maps to `smem_addr` 1199. `smem_addr` 0 corresponds to x=0..15, y=0..15.

## Configuration
- Macro: `VGA_CURSOR_EN`.
- Defined:
  - `cursor_col`/`cursor_row` ports exist.
  - A 6-bit frame counter increments on each falling edge of stage-1 vsync.
  - When counter bit 5 is 0 and the stage-2 cell matches the cursor cell, stage 3 outputs the bitwise inverse `~bmem_color` (still blanked outside active video).
  - The counter wraps 63→0, giving a ~1 s blink at 60 Hz.
  - A cursor outside the 40×30 grid never matches.
- Undefined: the cursor ports, counter and inversion logic are absent; colour is always `bmem_color`.

## Structure
- Shared package `display_pkg`: `COLS`, `ROWS`, cell size 16, colour typedef `rgb12_t` {r,g,b 4-bit}, and `PIPE_LAT = 3`. Reuse `xbits`/`ybits` from the existing display640x480 header.
- Sub-module `sync_delay` (parameterised depth, reset value 1) carries the hsync/vsync/activevideo side-band through the pipeline.

## Test plan
- Assert `reset` mid-stream → outputs immediately 0/0/0, hsync=vsync=1; after release, 3 cycles of blank before valid data.
- Drive x=0, y=0, active=1 → `smem_addr`=0 after 1 cycle; with `charcode`=4'h5 → `bmem_addr`=12'h500 after 2 cycles.
- Drive x=639, y=479 → `smem_addr`=1199; with `charcode`=3 → `bmem_addr`=12'h3FF.
- `bmem_color`=12'hF0A with active=1 then 0 → rgb=F0A at N+3, then 000 one cycle after active drops (also delayed 3).
- Pulse `hsync_in` low for 96 cycles → `hsync` low for exactly 96 cycles, starting 3 cycles later.
- With `VGA_CURSOR_EN`, cursor (2,1), `bmem_color`=12'h123 at x=32..47, y=16..31 → rgb=EDC for frames 0–31, 123 for frames 32–63, then EDC again after wrap.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display constants and types for the 640x480 character-cell pipeline.
// Cell geometry, colour struct, pipeline latency and timer coordinate widths.
package display_pkg;

    localparam int xbits     = 10;
    localparam int ybits     = 10;
    localparam int COLS      = 40;
    localparam int ROWS      = 30;
    localparam int CELL      = 16;
    localparam int CELL_BITS = $clog2(CELL);
    localparam int PIPE_LAT  = 3;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    // Linear cell index; y uses all its bits so off-screen rows simply land past 1199.
    function automatic logic [15:0] cell_index(input logic [xbits-1:0] x,
                                               input logic [ybits-1:0] y,
                                               input int               cols);
        return 16'(y >> CELL_BITS) * 16'(cols) + 16'(x >> CELL_BITS);
    endfunction

endpackage

// File: rtl/vga_char_display_if.sv
// Timer, memory and pin-side signals of the character display.
// slave is the display itself; master is whatever surrounds it (timer, memories, pins).
interface vga_char_display_if
    import display_pkg::*;
#(
    parameter int CHARBITS = 4,
    parameter int SMEM_AW  = 11
);
    logic [xbits-1:0]      x;
    logic [ybits-1:0]      y;
    logic                  activevideo;
    logic                  hsync_in;
    logic                  vsync_in;
    logic [SMEM_AW-1:0]    smem_addr;
    logic [CHARBITS-1:0]   charcode;
    logic [CHARBITS+7:0]   bmem_addr;
    logic [11:0]           bmem_color;
    logic [3:0]            red;
    logic [3:0]            green;
    logic [3:0]            blue;
    logic                  hsync;
    logic                  vsync;

    modport slave (
        input  x, y, activevideo, hsync_in, vsync_in, charcode, bmem_color,
        output smem_addr, bmem_addr, red, green, blue, hsync, vsync
    );

    modport master (
        output x, y, activevideo, hsync_in, vsync_in, charcode, bmem_color,
        input  smem_addr, bmem_addr, red, green, blue, hsync, vsync
    );
endinterface

// File: rtl/sync_delay.sv
// Fixed-depth shift register for side-band bits (syncs, activevideo).
// Latency DEPTH clocks; no backpressure, shifts every clock; resets to RST_VAL.
module sync_delay #(
    parameter int               DEPTH   = 3,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];
endmodule

// File: rtl/vga_char_display.sv
// Character-cell pixel generator: screen lookup, glyph lookup, blanked RGB; 3-clock latency.
// Free-running, no backpressure. Optional blinking cursor inversion under VGA_CURSOR_EN.
module vga_char_display
    import display_pkg::*;
#(
    parameter int COLS     = display_pkg::COLS,
    parameter int ROWS     = display_pkg::ROWS,
    parameter int CHARBITS = 4,
    parameter int SMEM_AW  = 11
) (
    input  logic clk,
    input  logic reset,
`ifdef VGA_CURSOR_EN
    input  logic [5:0] cursor_col,
    input  logic [4:0] cursor_row,
`endif
    vga_char_display_if.slave bus
);
    localparam int CB = CELL_BITS;

    logic [CB-1:0] x1_lo, y1_lo;
    logic          act2;
    logic [1:0]    sync_q;
    rgb12_t        pix;
    rgb12_t        glyph;

    assign glyph = rgb12_t'(bus.bmem_color);

    sync_delay #(.DEPTH(PIPE_LAT), .WIDTH(2), .RST_VAL(2'b11)) u_sync (
        .clk(clk), .reset(reset), .d({bus.hsync_in, bus.vsync_in}), .q(sync_q)
    );

    // activevideo only needs to reach stage 2, where it gates the colour register.
    sync_delay #(.DEPTH(PIPE_LAT-1), .WIDTH(1), .RST_VAL(1'b0)) u_act (
        .clk(clk), .reset(reset), .d(bus.activevideo), .q(act2)
    );

`ifdef VGA_CURSOR_EN
    logic [5:0] col1, row1, col2, row2;
    logic       vs1, vs1_prev;
    logic [5:0] frame_cnt;
    logic       cursor_hit;

    assign cursor_hit = !frame_cnt[5]
                      && (cursor_col < 6'(COLS)) && (cursor_row < 5'(ROWS))
                      && (col2 == cursor_col) && (row2 == {1'b0, cursor_row});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col1      <= '0;
            row1      <= '0;
            col2      <= '0;
            row2      <= '0;
            vs1       <= 1'b1;
            vs1_prev  <= 1'b1;
            frame_cnt <= '0;
        end else begin
            col1     <= 6'(bus.x >> CB);
            row1     <= 6'(bus.y >> CB);
            col2     <= col1;
            row2     <= row1;
            vs1      <= bus.vsync_in;
            vs1_prev <= vs1;
            if (vs1_prev && !vs1) frame_cnt <= frame_cnt + 6'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.smem_addr <= '0;
            x1_lo         <= '0;
            y1_lo         <= '0;
            bus.bmem_addr <= '0;
            pix           <= '0;
        end else begin
            bus.smem_addr <= SMEM_AW'(cell_index(bus.x, bus.y, COLS));
            x1_lo         <= bus.x[CB-1:0];
            y1_lo         <= bus.y[CB-1:0];
            bus.bmem_addr <= {bus.charcode, y1_lo, x1_lo};
`ifdef VGA_CURSOR_EN
            pix <= !act2 ? '0 : (cursor_hit ? ~glyph : glyph);
`else
            pix <= act2 ? glyph : '0;
`endif
        end
    end

    assign bus.red   = pix.r;
    assign bus.green = pix.g;
    assign bus.blue  = pix.b;
    assign bus.hsync = sync_q[1];
    assign bus.vsync = sync_q[0];
endmodule

// File: tb/tb_vga_char_display.sv
// Directed bench for vga_char_display: address mapping, colour/blanking, sync delay,
// asynchronous reset recovery and (with VGA_CURSOR_EN) cursor blink.
module tb_vga_char_display;
    import display_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_char_display_if #(.CHARBITS(4), .SMEM_AW(11)) bus();

`ifdef VGA_CURSOR_EN
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;
`endif

    // Screen memory: cell 0 holds 5, cell 1199 holds 3, others their low address nibble.
    logic [3:0]  smem [2048];
    logic        bmem_ovr_en;
    logic [11:0] bmem_ovr;
    logic [11:0] rgb;

    assign bus.charcode   = smem[bus.smem_addr];
    assign bus.bmem_color = bmem_ovr_en ? bmem_ovr : bus.bmem_addr;
    assign rgb            = {bus.red, bus.green, bus.blue};

    int n_cmp = 0;
    int n_bad = 0;

    vga_char_display #(.COLS(40), .ROWS(30), .CHARBITS(4), .SMEM_AW(11)) dut (
        .clk(clk),
        .reset(reset),
`ifdef VGA_CURSOR_EN
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
`endif
        .bus(bus.slave)
    );

    task automatic drive(input int xv, input int yv, input logic a, input logic hs, input logic vs);
        bus.x           = 10'(xv);
        bus.y           = 10'(yv);
        bus.activevideo = a;
        bus.hsync_in    = hs;
        bus.vsync_in    = vs;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(250, 0, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        n_cmp++; if (bus.smem_addr !== 11'd0) begin n_bad++; $display("FAIL reset_smem got %0d want 0", bus.smem_addr); end
        n_cmp++; if (bus.bmem_addr !== 12'h000) begin n_bad++; $display("FAIL reset_bmem got %h want 000", bus.bmem_addr); end
        n_cmp++; if (rgb !== 12'h000) begin n_bad++; $display("FAIL reset_rgb got %h want 000", rgb); end
        n_cmp++; if (bus.hsync !== 1'b1) begin n_bad++; $display("FAIL reset_hsync got %b want 1", bus.hsync); end
        n_cmp++; if (bus.vsync !== 1'b1) begin n_bad++; $display("FAIL reset_vsync got %b want 1", bus.vsync); end
        reset = 1'b0;
    endtask

    task automatic test_addr_bottom_right();
        drive(639, 479, 1'b1, 1'b1, 1'b1);
        tick();
        n_cmp++; if (bus.smem_addr !== 11'd1199) begin n_bad++; $display("FAIL br_smem got %0d want 1199", bus.smem_addr); end
        tick();
        n_cmp++; if (bus.bmem_addr !== 12'h3FF) begin n_bad++; $display("FAIL br_bmem got %h want 3FF", bus.bmem_addr); end
        tick();
        n_cmp++; if (rgb !== 12'h3FF) begin n_bad++; $display("FAIL br_rgb got %h want 3FF", rgb); end
    endtask

    task automatic test_addr_origin();
        drive(0, 0, 1'b1, 1'b1, 1'b1);
        tick();
        n_cmp++; if (bus.smem_addr !== 11'd0) begin n_bad++; $display("FAIL org_smem got %0d want 0", bus.smem_addr); end
        tick();
        n_cmp++; if (bus.bmem_addr !== 12'h500) begin n_bad++; $display("FAIL org_bmem got %h want 500", bus.bmem_addr); end
        tick();
        n_cmp++; if (rgb !== 12'h500) begin n_bad++; $display("FAIL org_rgb got %h want 500", rgb); end
        // Interior cell: col 7 row 3 -> 127, charcode F, glyph row 9, glyph col 2.
        drive(7*16+2, 3*16+9, 1'b1, 1'b1, 1'b1);
        tick();
        n_cmp++; if (bus.smem_addr !== 11'd127) begin n_bad++; $display("FAIL mid_smem got %0d want 127", bus.smem_addr); end
        tick();
        n_cmp++; if (bus.bmem_addr !== 12'hF92) begin n_bad++; $display("FAIL mid_bmem got %h want F92", bus.bmem_addr); end
    endtask

    task automatic test_color_blank();
        // Cell 15 holds charcode F; x low nibble A, y low nibble 0 -> colour F0A.
        drive(250, 0, 1'b1, 1'b1, 1'b1);
        tick();
        bus.activevideo = 1'b0;
        tick();
        tick();
        n_cmp++; if (rgb !== 12'hF0A) begin n_bad++; $display("FAIL color_active got %h want F0A", rgb); end
        tick();
        n_cmp++; if (rgb !== 12'h000) begin n_bad++; $display("FAIL color_blank got %h want 000", rgb); end
    endtask

    task automatic test_hsync_pulse();
        int low_cnt = 0;
        int first   = -1;
        int last    = -1;
        int vs_low  = 0;
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 110; i++) begin
            tick();
            if (!bus.hsync) begin
                low_cnt++;
                if (first < 0) first = i;
                last = i;
            end
            if (!bus.vsync) vs_low++;
            if (i == 96) bus.hsync_in = 1'b1;
        end
        n_cmp++; if (low_cnt != 96) begin n_bad++; $display("FAIL hs_width got %0d want 96", low_cnt); end
        n_cmp++; if (first != 3) begin n_bad++; $display("FAIL hs_start got %0d want 3", first); end
        n_cmp++; if (last != 98) begin n_bad++; $display("FAIL hs_end got %0d want 98", last); end
        n_cmp++; if (vs_low != 0) begin n_bad++; $display("FAIL vs_quiet got %0d want 0", vs_low); end
    endtask

    task automatic test_reset_mid();
        drive(250, 0, 1'b1, 1'b0, 1'b1);
        repeat (4) tick();
        n_cmp++; if (rgb !== 12'hF0A) begin n_bad++; $display("FAIL mid_pre_rgb got %h want F0A", rgb); end
        n_cmp++; if (bus.hsync !== 1'b0) begin n_bad++; $display("FAIL mid_pre_hsync got %b want 0", bus.hsync); end
        reset = 1'b1;
        #1;
        n_cmp++; if (rgb !== 12'h000) begin n_bad++; $display("FAIL mid_async_rgb got %h want 000", rgb); end
        n_cmp++; if (bus.hsync !== 1'b1) begin n_bad++; $display("FAIL mid_async_hsync got %b want 1", bus.hsync); end
        n_cmp++; if (bus.smem_addr !== 11'd0) begin n_bad++; $display("FAIL mid_async_smem got %0d want 0", bus.smem_addr); end
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_cmp++; if (rgb !== 12'h000) begin n_bad++; $display("FAIL rel_blank_rgb cyc %0d got %h want 000", i, rgb); end
            n_cmp++; if (bus.hsync !== 1'b1) begin n_bad++; $display("FAIL rel_blank_hsync cyc %0d got %b want 1", i, bus.hsync); end
        end
        tick();
        n_cmp++; if (rgb !== 12'hF0A) begin n_bad++; $display("FAIL rel_valid_rgb got %h want F0A", rgb); end
        n_cmp++; if (bus.hsync !== 1'b0) begin n_bad++; $display("FAIL rel_valid_hsync got %b want 0", bus.hsync); end
    endtask

`ifdef VGA_CURSOR_EN
    task automatic vsync_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            bus.vsync_in = 1'b0;
            tick();
            bus.vsync_in = 1'b1;
            tick();
        end
        repeat (4) tick();
    endtask

    task automatic test_cursor();
        cursor_col  = 6'd2;
        cursor_row  = 5'd1;
        bmem_ovr_en = 1'b1;
        bmem_ovr    = 12'h123;
        drive(40, 20, 1'b1, 1'b1, 1'b1);
        repeat (4) tick();
        n_cmp++; if (rgb !== 12'hEDC) begin n_bad++; $display("FAIL cur_f0 got %h want EDC", rgb); end
        drive(48, 20, 1'b1, 1'b1, 1'b1);
        repeat (4) tick();
        n_cmp++; if (rgb !== 12'h123) begin n_bad++; $display("FAIL cur_other got %h want 123", rgb); end
        drive(47, 31, 1'b1, 1'b1, 1'b1);
        vsync_pulses(31);
        n_cmp++; if (rgb !== 12'hEDC) begin n_bad++; $display("FAIL cur_f31 got %h want EDC", rgb); end
        vsync_pulses(1);
        n_cmp++; if (rgb !== 12'h123) begin n_bad++; $display("FAIL cur_f32 got %h want 123", rgb); end
        vsync_pulses(32);
        n_cmp++; if (rgb !== 12'hEDC) begin n_bad++; $display("FAIL cur_wrap got %h want EDC", rgb); end
        bus.activevideo = 1'b0;
        repeat (4) tick();
        n_cmp++; if (rgb !== 12'h000) begin n_bad++; $display("FAIL cur_blank got %h want 000", rgb); end
        cursor_col = 6'd45;
        bus.x = 10'(45*16);
        bus.activevideo = 1'b1;
        repeat (4) tick();
        n_cmp++; if (rgb !== 12'h123) begin n_bad++; $display("FAIL cur_offgrid got %h want 123", rgb); end
        bmem_ovr_en = 1'b0;
    endtask
`endif

    initial begin
        for (int a = 0; a < 2048; a++) smem[a] = 4'(a);
        smem[0]    = 4'h5;
        smem[1199] = 4'h3;
        bmem_ovr_en = 1'b0;
        bmem_ovr    = 12'h000;
`ifdef VGA_CURSOR_EN
        cursor_col = 6'd63;
        cursor_row = 5'd31;
`endif
        @(negedge clk);
        test_reset();
        test_addr_bottom_right();
        test_addr_origin();
        test_color_blank();
        test_hsync_pulse();
        test_reset_mid();
`ifdef VGA_CURSOR_EN
        test_cursor();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
